// File: rtl/reg_file_sb_pkg.sv
// Shared types and condition-code helpers for the bypassed, scoreboarded register file.
package reg_file_sb_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [2:0]        nzp_t;

  localparam nzp_t NZP_N = 3'b100;
  localparam nzp_t NZP_Z = 3'b010;
  localparam nzp_t NZP_P = 3'b001;

  // Exactly one bit set for any input value.
  function automatic nzp_t nzp_of(word_t w);
    if (w[WORD_W-1]) return NZP_N;
    else if (w == '0) return NZP_Z;
    else return NZP_P;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Read/write/reserve bus between the datapath and the register file.
interface reg_file_sb_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = $clog2(NUM_REGS)
);
  logic             Load;
  logic [IDX_W-1:0] DR;
  logic [WIDTH-1:0] D;
  logic             LD_CC;
  logic             Reserve;
  logic [IDX_W-1:0] Reserve_Idx;
  logic [IDX_W-1:0] SR1;
  logic [IDX_W-1:0] SR2;
  logic [WIDTH-1:0] SR1_Out;
  logic [WIDTH-1:0] SR2_Out;
  logic             SR1_Busy;
  logic             SR2_Busy;
  logic [2:0]       NZP;
  logic             Reserve_Err;

  modport master (
    output Load, DR, D, LD_CC, Reserve, Reserve_Idx, SR1, SR2,
    input  SR1_Out, SR2_Out, SR1_Busy, SR2_Busy, NZP, Reserve_Err
  );

  modport slave (
    input  Load, DR, D, LD_CC, Reserve, Reserve_Idx, SR1, SR2,
    output SR1_Out, SR2_Out, SR1_Busy, SR2_Busy, NZP, Reserve_Err
  );
endinterface

// File: rtl/reg_file_sb_nzp_calc.sv
// Combinational {N,Z,P} decode of a data word.
module nzp_calc
  import reg_file_sb_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] d_i,
  output nzp_t             nzp_o
);

  generate
    if (WIDTH == WORD_W) begin : g_pkg
      assign nzp_o = nzp_of(word_t'(d_i));
    end else begin : g_gen
      logic neg, zero;
      assign neg   = d_i[WIDTH-1];
      assign zero  = (d_i == '0);
      assign nzp_o = {neg, zero, !neg && !zero};
    end
  endgenerate

endmodule

// File: rtl/reg_file_sb.sv
// Register file with same-cycle write bypass, per-register busy scoreboard and NZP register.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               NUM_REGS  = 8,
  parameter int               IDX_W     = $clog2(NUM_REGS),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic         Clk,
  input logic         Reset,
  reg_file_sb_if.slave bus
);

  localparam int             RD_PORTS = 2;
  localparam logic [IDX_W:0] NREG     = (IDX_W+1)'(NUM_REGS);

  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [WIDTH-1:0]    regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  nzp_t                nzp_q, nzp_d, nzp_bus, nzp_rst;
  logic                rerr_q, rerr_d;
  logic                wr_ok, rsv_ok;

  logic [RD_PORTS-1:0][IDX_W-1:0] sr;
  logic [RD_PORTS-1:0][WIDTH-1:0] rd;
  logic [RD_PORTS-1:0]            rbusy;

  // Indices can exceed NUM_REGS when it is not a power of two.
  function automatic logic in_range(logic [IDX_W-1:0] idx);
    return {1'b0, idx} < NREG;
  endfunction

  assign wr_ok  = bus.Load && in_range(bus.DR);
  assign rsv_ok = bus.Reserve && in_range(bus.Reserve_Idx);
  assign sr     = {bus.SR2, bus.SR1};

  generate
    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
      logic ok, hit;
      assign ok       = in_range(sr[p]);
      assign hit      = wr_ok && (bus.DR == sr[p]);
      assign rd[p]    = hit ? bus.D : (ok ? regs_q[sr[p]] : '0);
      assign rbusy[p] = !hit && ok && busy_q[sr[p]];
    end
  endgenerate

  assign bus.SR1_Out     = rd[0];
  assign bus.SR2_Out     = rd[1];
  assign bus.SR1_Busy    = rbusy[0];
  assign bus.SR2_Busy    = rbusy[1];
  assign bus.NZP         = nzp_q;
  assign bus.Reserve_Err = rerr_q;

  nzp_calc #(.WIDTH(WIDTH)) u_nzp_bus (.d_i(bus.D),     .nzp_o(nzp_bus));
  nzp_calc #(.WIDTH(WIDTH)) u_nzp_rst (.d_i(RESET_VAL), .nzp_o(nzp_rst));

  // Reserve is applied after the write so a new producer keeps the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[bus.DR] = bus.D;
      busy_d[bus.DR] = 1'b0;
    end
    if (rsv_ok) busy_d[bus.Reserve_Idx] = 1'b1;
    rerr_d = rsv_ok && busy_q[bus.Reserve_Idx] && !(wr_ok && (bus.DR == bus.Reserve_Idx));
    nzp_d  = bus.LD_CC ? nzp_bus : nzp_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      busy_q <= '0;
      rerr_q <= 1'b0;
      nzp_q  <= nzp_rst;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      rerr_q <= rerr_d;
      nzp_q  <= nzp_d;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed checks of bypass, scoreboard, NZP and out-of-range handling on 8- and 6-entry files.
module tb_reg_file_sb;

  logic Clk = 1'b0;
  logic Reset;
  int   total, bad;

  always #5 Clk = ~Clk;

  reg_file_sb_if #(.WIDTH(16), .NUM_REGS(8)) b8 ();
  reg_file_sb_if #(.WIDTH(16), .NUM_REGS(6)) b6 ();

  reg_file_sb #(.WIDTH(16), .NUM_REGS(8)) dut8 (.Clk(Clk), .Reset(Reset), .bus(b8));
  reg_file_sb #(.WIDTH(16), .NUM_REGS(6)) dut6 (.Clk(Clk), .Reset(Reset), .bus(b6));

  task automatic idle();
    b8.Load = 0; b8.DR = 0; b8.D = 0; b8.LD_CC = 0; b8.Reserve = 0; b8.Reserve_Idx = 0;
    b8.SR1 = 0; b8.SR2 = 0;
    b6.Load = 0; b6.DR = 0; b6.D = 0; b6.LD_CC = 0; b6.Reserve = 0; b6.Reserve_Idx = 0;
    b6.SR1 = 0; b6.SR2 = 0;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    Reset = 0;
    // Put state in place for reset to clear: R1, busy[4], NZP=P.
    b8.Load = 1; b8.DR = 1; b8.D = 16'h1111; b8.LD_CC = 1; b8.Reserve = 1; b8.Reserve_Idx = 4;
    tick();
    b8.D = 16'hBEEF;
    #2 Reset = 1;
    #1;
    total++; if (b8.NZP !== 3'b010) begin bad++; $display("FAIL rst_async_nzp got=%b want=010", b8.NZP); end
    tick();
    total++; if (b8.NZP !== 3'b010) begin bad++; $display("FAIL rst_hold_nzp got=%b want=010", b8.NZP); end
    total++; if (b8.Reserve_Err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", b8.Reserve_Err); end
    idle();
    for (int i = 0; i < 8; i++) begin
      b8.SR1 = 3'(i); b8.SR2 = 3'(i); #1;
      total++; if (b8.SR1_Out !== 16'h0) begin bad++; $display("FAIL rst_rd r%0d got=%h want=0000", i, b8.SR1_Out); end
      total++; if (b8.SR2_Busy !== 1'b0) begin bad++; $display("FAIL rst_busy r%0d got=%b want=0", i, b8.SR2_Busy); end
    end
    tick();
    Reset = 0;
    tick();
    b8.SR1 = 1; b8.SR2 = 4; #1;
    total++; if (b8.SR1_Out !== 16'h0) begin bad++; $display("FAIL rst_nowrite got=%h want=0000", b8.SR1_Out); end
    total++; if (b8.SR2_Busy !== 1'b0) begin bad++; $display("FAIL rst_busy4 got=%b want=0", b8.SR2_Busy); end
    tick();
  endtask

  task automatic test_write_bypass();
    b8.Load = 1; b8.DR = 3; b8.D = 16'h1234; b8.SR1 = 3; b8.SR2 = 3; #1;
    total++; if (b8.SR1_Out !== 16'h1234) begin bad++; $display("FAIL byp_sr1 got=%h want=1234", b8.SR1_Out); end
    total++; if (b8.SR2_Out !== 16'h1234) begin bad++; $display("FAIL byp_sr2 got=%h want=1234", b8.SR2_Out); end
    tick();
    b8.Load = 0; #1;
    total++; if (b8.SR1_Out !== 16'h1234) begin bad++; $display("FAIL held_sr1 got=%h want=1234", b8.SR1_Out); end
    b8.Load = 1; b8.DR = 1; b8.D = 16'h0A0A;
    tick();
    b8.DR = 6; b8.D = 16'hF00F; b8.SR1 = 1; b8.SR2 = 6; #1;
    total++; if (b8.SR1_Out !== 16'h0A0A) begin bad++; $display("FAIL b2b_r1 got=%h want=0a0a", b8.SR1_Out); end
    total++; if (b8.SR2_Out !== 16'hF00F) begin bad++; $display("FAIL b2b_byp6 got=%h want=f00f", b8.SR2_Out); end
    tick();
    b8.Load = 0; b8.SR1 = 6; b8.SR2 = 3; #1;
    total++; if (b8.SR1_Out !== 16'hF00F) begin bad++; $display("FAIL b2b_r6 got=%h want=f00f", b8.SR1_Out); end
    total++; if (b8.SR2_Out !== 16'h1234) begin bad++; $display("FAIL b2b_r3 got=%h want=1234", b8.SR2_Out); end
    tick();
  endtask

  task automatic test_nzp();
    b8.LD_CC = 1; b8.Load = 0; b8.D = 16'h8000; b8.SR1 = 0;
    tick();
    total++; if (b8.NZP !== 3'b100) begin bad++; $display("FAIL nzp_neg got=%b want=100", b8.NZP); end
    b8.D = 16'h0000;
    tick();
    total++; if (b8.NZP !== 3'b010) begin bad++; $display("FAIL nzp_zero got=%b want=010", b8.NZP); end
    b8.D = 16'h7FFF;
    tick();
    total++; if (b8.NZP !== 3'b001) begin bad++; $display("FAIL nzp_pos got=%b want=001", b8.NZP); end
    b8.LD_CC = 0; b8.D = 16'h8000;
    tick();
    total++; if (b8.NZP !== 3'b001) begin bad++; $display("FAIL nzp_hold got=%b want=001", b8.NZP); end
    total++; if (b8.SR1_Out !== 16'h0) begin bad++; $display("FAIL nzp_noreg got=%h want=0000", b8.SR1_Out); end
  endtask

  task automatic test_busy();
    b8.Reserve = 1; b8.Reserve_Idx = 5; b8.SR2 = 5; #1;
    total++; if (b8.SR2_Busy !== 1'b0) begin bad++; $display("FAIL busy_pre got=%b want=0", b8.SR2_Busy); end
    tick();
    b8.Reserve = 0; b8.SR1 = 5; #1;
    total++; if (b8.SR2_Busy !== 1'b1) begin bad++; $display("FAIL busy_set2 got=%b want=1", b8.SR2_Busy); end
    total++; if (b8.SR1_Busy !== 1'b1) begin bad++; $display("FAIL busy_set1 got=%b want=1", b8.SR1_Busy); end
    b8.Load = 1; b8.DR = 5; b8.D = 16'h55AA; #1;
    total++; if (b8.SR2_Busy !== 1'b0) begin bad++; $display("FAIL busy_inflight got=%b want=0", b8.SR2_Busy); end
    total++; if (b8.SR2_Out !== 16'h55AA) begin bad++; $display("FAIL busy_byp got=%h want=55aa", b8.SR2_Out); end
    tick();
    b8.Load = 0; #1;
    total++; if (b8.SR2_Busy !== 1'b0) begin bad++; $display("FAIL busy_clr got=%b want=0", b8.SR2_Busy); end
    total++; if (b8.SR2_Out !== 16'h55AA) begin bad++; $display("FAIL busy_data got=%h want=55aa", b8.SR2_Out); end
    tick();
  endtask

  task automatic test_reserve_err();
    b8.Reserve = 1; b8.Reserve_Idx = 2; b8.SR1 = 2;
    tick();
    total++; if (b8.Reserve_Err !== 1'b0) begin bad++; $display("FAIL rerr_first got=%b want=0", b8.Reserve_Err); end
    tick();
    total++; if (b8.Reserve_Err !== 1'b1) begin bad++; $display("FAIL rerr_second got=%b want=1", b8.Reserve_Err); end
    b8.Load = 1; b8.DR = 2; b8.D = 16'hABCD; #1;
    total++; if (b8.SR1_Busy !== 1'b0) begin bad++; $display("FAIL rsvld_inflight got=%b want=0", b8.SR1_Busy); end
    tick();
    total++; if (b8.Reserve_Err !== 1'b0) begin bad++; $display("FAIL rsvld_err got=%b want=0", b8.Reserve_Err); end
    b8.Load = 0; b8.Reserve = 0; #1;
    total++; if (b8.SR1_Out !== 16'hABCD) begin bad++; $display("FAIL rsvld_data got=%h want=abcd", b8.SR1_Out); end
    total++; if (b8.SR1_Busy !== 1'b1) begin bad++; $display("FAIL rsvld_busy got=%b want=1", b8.SR1_Busy); end
    b8.Reserve = 1;
    tick();
    total++; if (b8.Reserve_Err !== 1'b1) begin bad++; $display("FAIL rerr_again got=%b want=1", b8.Reserve_Err); end
    b8.Reserve = 0;
    tick();
    total++; if (b8.Reserve_Err !== 1'b0) begin bad++; $display("FAIL rerr_pulse got=%b want=0", b8.Reserve_Err); end
  endtask

  task automatic test_oob();
    logic [15:0] mdl [6];
    logic [15:0] want1, want2;
    for (int i = 0; i < 6; i++) mdl[i] = '0;
    total++; if (b6.NZP !== 3'b010) begin bad++; $display("FAIL oob_nzp got=%b want=010", b6.NZP); end
    b6.Load = 1; b6.DR = 7; b6.D = 16'hFFFF; b6.SR1 = 7; b6.Reserve = 1; b6.Reserve_Idx = 7; #1;
    total++; if (b6.SR1_Out !== 16'h0) begin bad++; $display("FAIL oob_byp got=%h want=0000", b6.SR1_Out); end
    tick();
    b6.Load = 0; b6.Reserve_Idx = 6;
    tick();
    total++; if (b6.Reserve_Err !== 1'b0) begin bad++; $display("FAIL oob_rerr got=%b want=0", b6.Reserve_Err); end
    b6.Reserve = 0; b6.SR2 = 6; #1;
    total++; if (b6.SR2_Busy !== 1'b0) begin bad++; $display("FAIL oob_busy got=%b want=0", b6.SR2_Busy); end
    for (int i = 0; i < 6; i++) begin
      b6.SR1 = 3'(i); #1;
      total++; if (b6.SR1_Out !== 16'h0) begin bad++; $display("FAIL oob_nochg r%0d got=%h want=0000", i, b6.SR1_Out); end
    end
    tick();
    for (int n = 0; n < 40; n++) begin
      b6.Load = 1'($urandom_range(0, 1));
      b6.DR   = 3'($urandom_range(0, 7));
      b6.D    = 16'($urandom);
      b6.SR1  = 3'($urandom_range(0, 7));
      b6.SR2  = 3'($urandom_range(0, 7));
      #1;
      want1 = 16'h0; want2 = 16'h0;
      if (b6.SR1 < 6) want1 = (b6.Load && b6.DR == b6.SR1) ? b6.D : mdl[b6.SR1];
      if (b6.SR2 < 6) want2 = (b6.Load && b6.DR == b6.SR2) ? b6.D : mdl[b6.SR2];
      total++; if (b6.SR1_Out !== want1) begin bad++; $display("FAIL rnd_sr1 n=%0d idx=%0d got=%h want=%h", n, b6.SR1, b6.SR1_Out, want1); end
      total++; if (b6.SR2_Out !== want2) begin bad++; $display("FAIL rnd_sr2 n=%0d idx=%0d got=%h want=%h", n, b6.SR2, b6.SR2_Out, want2); end
      if (b6.Load && b6.DR < 6) mdl[b6.DR] = b6.D;
      tick();
    end
    idle();
  endtask

  initial begin
    total = 0; bad = 0;
    Reset = 1;
    idle();
    test_reset();
    test_write_bypass();
    test_nzp();
    test_busy();
    test_reserve_err();
    test_oob();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
